// File: rtl/mlab_stream_pkg.sv
// -----------------------------------------------------------------------------
// mlab_stream_pkg
// Shared types and constants for the sample-playback / Costas-loop stream
// sequencer.
//   stream_state_t : run state of the sequencer (IDLE, STREAM, DRAIN, DONE)
//   SAMPLE_ADDR_W  : default sample RAM address width
//   SAMPLE_COUNT   : default samples per playback pass
//   CAP_DECIM_10K  : clock cycles per capture strobe (10 MHz -> 10 kHz)
// -----------------------------------------------------------------------------
package mlab_stream_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    DRAIN  = 2'd2,
    DONE   = 2'd3
  } stream_state_t;

  localparam int SAMPLE_ADDR_W = 22;
  localparam int SAMPLE_COUNT  = 810000;
  localparam int CAP_DECIM_10K = 1000;

endpackage

// File: rtl/sample_stream_ctrl_decim_strobe.sv
// -----------------------------------------------------------------------------
// decim_strobe
// Enable-gated modulo-DECIM counter producing a one-cycle strobe in the cycle
// the counter sits at DECIM-1. The counter is forced to zero whenever it is
// not enabled or clr is high, so every enabled interval restarts the phase.
// Ports:
//   CLK : clock
//   RST : asynchronous reset, active-low
//   en  : count enable for the coming cycle
//   clr : restart the count at zero (wins over en)
//   stb : registered strobe, high while the count equals DECIM-1
// -----------------------------------------------------------------------------
module decim_strobe
  import mlab_stream_pkg::*;
#(
  parameter int DECIM = CAP_DECIM_10K
) (
  input  logic CLK,
  input  logic RST,
  input  logic en,
  input  logic clr,
  output logic stb
);

  localparam int              CNT_W    = $clog2(DECIM);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DECIM - 1);

  if (DECIM < 2) begin : g_bad_decim
    $error("decim_strobe: DECIM must be at least 2");
  end

  logic [CNT_W-1:0] cnt_reg;
  logic [CNT_W-1:0] cnt_next;
  logic             stb_reg;

  always_comb begin
    cnt_next = '0;
    if (en && !clr) begin
      cnt_next = (cnt_reg == CNT_LAST) ? '0 : cnt_reg + 1'b1;
    end
  end

  // Strobe is decoded from the next count so it lines up with cnt_reg.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      cnt_reg <= '0;
      stb_reg <= 1'b0;
    end else begin
      cnt_reg <= cnt_next;
      stb_reg <= (cnt_next == CNT_LAST);
    end
  end

  assign stb = stb_reg;

endmodule

// File: rtl/sample_stream_ctrl.sv
// -----------------------------------------------------------------------------
// sample_stream_ctrl
// Sequencer for the sample-playback datapath: one controlled run that streams
// NUM_SAMPLES RAM addresses (optionally looping), drains the RAM/datapath
// pipeline, then reports done. Also produces the decimated capture strobe and
// the capture buffer write port.
// Ports:
//   CLK       : clock
//   RST       : asynchronous reset, active-low
//   start     : single-cycle run request (accepted in IDLE or DONE)
//   abort     : single-cycle run cancel (wins over start)
//   loop_en   : at the last address, wrap to 0 instead of draining
//   ram_addr  : sample RAM read address
//   ram_en    : sample RAM read enable
//   dp_rst    : datapath hold-in-reset (high in IDLE)
//   dp_valid  : RAM data at datapath input valid (ram_en delayed RAM_LAT)
//   cap_stb   : one-cycle tick every DECIM busy cycles
//   cap_we    : capture buffer write enable
//   cap_addr  : capture buffer write address
//   busy      : STREAM or DRAIN
//   done      : run completed (level)
//   overflow  : sticky, a capture strobe found the buffer full
// -----------------------------------------------------------------------------
module sample_stream_ctrl
  import mlab_stream_pkg::*;
#(
  parameter int ADDR_W      = SAMPLE_ADDR_W,
  parameter int NUM_SAMPLES = SAMPLE_COUNT,
  parameter int RAM_LAT     = 1,
  parameter int DECIM       = CAP_DECIM_10K,
  parameter int DRAIN_CYC   = 16,
  parameter int OUT_ADDR_W  = 10
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  start,
  input  logic                  abort,
  input  logic                  loop_en,
  output logic [ADDR_W-1:0]     ram_addr,
  output logic                  ram_en,
  output logic                  dp_rst,
  output logic                  dp_valid,
  output logic                  cap_stb,
  output logic                  cap_we,
  output logic [OUT_ADDR_W-1:0] cap_addr,
  output logic                  busy,
  output logic                  done,
  output logic                  overflow
);

  localparam logic [ADDR_W-1:0]  LAST_ADDR  = ADDR_W'(NUM_SAMPLES - 1);
  localparam int                 DRAIN_LEN  = RAM_LAT + DRAIN_CYC;
  localparam int                 DRAIN_W    = $clog2(DRAIN_LEN + 1);
  localparam logic [DRAIN_W-1:0] DRAIN_LAST = DRAIN_W'(DRAIN_LEN - 1);

  if (longint'(NUM_SAMPLES) > (longint'(1) << ADDR_W)) begin : g_bad_addr_w
    $error("sample_stream_ctrl: NUM_SAMPLES does not fit in ADDR_W bits");
  end
  if (RAM_LAT < 1) begin : g_bad_ram_lat
    $error("sample_stream_ctrl: RAM_LAT must be at least 1");
  end

  stream_state_t          state_reg;
  logic [ADDR_W-1:0]      ram_addr_reg;
  logic                   ram_en_reg;
  logic                   dp_rst_reg;
  logic                   busy_reg;
  logic                   done_reg;
  logic [DRAIN_W-1:0]     drain_cnt_reg;
  logic [RAM_LAT-1:0]     vld_pipe_reg;
  logic [OUT_ADDR_W-1:0]  cap_addr_reg;
  logic                   full_reg;
  logic                   overflow_reg;

  logic                   start_go;
  logic                   abort_go;
  logic                   busy_next;
  logic                   cap_stb_int;

  // Abort only acts on an active run; start only when no run is in flight.
  assign abort_go = abort && (state_reg != IDLE);
  assign start_go = start && !abort && ((state_reg == IDLE) || (state_reg == DONE));

  // The decimator is driven by next-cycle busy so its count is already zero
  // in the first busy cycle and never reaches DECIM-1 outside busy.
  always_comb begin
    busy_next = busy_reg;
    if (abort_go) begin
      busy_next = 1'b0;
    end else if (start_go) begin
      busy_next = 1'b1;
    end else if ((state_reg == DRAIN) && (drain_cnt_reg == DRAIN_LAST)) begin
      busy_next = 1'b0;
    end
  end

  decim_strobe #(
    .DECIM (DECIM)
  ) u_decim (
    .CLK (CLK),
    .RST (RST),
    .en  (busy_next),
    .clr (start_go),
    .stb (cap_stb_int)
  );

  // Run sequencer.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_reg     <= IDLE;
      ram_addr_reg  <= '0;
      ram_en_reg    <= 1'b0;
      dp_rst_reg    <= 1'b1;
      busy_reg      <= 1'b0;
      done_reg      <= 1'b0;
      drain_cnt_reg <= '0;
    end else if (abort_go) begin
      state_reg     <= IDLE;
      ram_addr_reg  <= '0;
      ram_en_reg    <= 1'b0;
      dp_rst_reg    <= 1'b1;
      busy_reg      <= 1'b0;
      done_reg      <= 1'b0;
      drain_cnt_reg <= '0;
    end else if (start_go) begin
      state_reg     <= STREAM;
      ram_addr_reg  <= '0;
      ram_en_reg    <= 1'b1;
      dp_rst_reg    <= 1'b0;
      busy_reg      <= 1'b1;
      done_reg      <= 1'b0;
      drain_cnt_reg <= '0;
    end else begin
      case (state_reg)
        STREAM: begin
          if (ram_addr_reg == LAST_ADDR) begin
            if (loop_en) begin
              ram_addr_reg <= '0;
            end else begin
              // Address holds at the last sample through DRAIN/DONE.
              state_reg     <= DRAIN;
              ram_en_reg    <= 1'b0;
              drain_cnt_reg <= '0;
            end
          end else begin
            ram_addr_reg <= ram_addr_reg + 1'b1;
          end
        end
        DRAIN: begin
          if (drain_cnt_reg == DRAIN_LAST) begin
            state_reg <= DONE;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b1;
          end else begin
            drain_cnt_reg <= drain_cnt_reg + 1'b1;
          end
        end
        default: begin
          // IDLE and DONE hold until start/abort.
        end
      endcase
    end
  end

  // RAM latency model for the valid flag; flushed at once on abort.
  for (genvar gi = 0; gi < RAM_LAT; gi++) begin : g_vld
    if (gi == 0) begin : g_head
      always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
          vld_pipe_reg[gi] <= 1'b0;
        end else if (abort_go) begin
          vld_pipe_reg[gi] <= 1'b0;
        end else begin
          vld_pipe_reg[gi] <= ram_en_reg;
        end
      end
    end else begin : g_tail
      always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
          vld_pipe_reg[gi] <= 1'b0;
        end else if (abort_go) begin
          vld_pipe_reg[gi] <= 1'b0;
        end else begin
          vld_pipe_reg[gi] <= vld_pipe_reg[gi-1];
        end
      end
    end
  end

  // Capture buffer write port. cap_addr and overflow survive abort so the
  // buffer can be read back; both are cleared by the next start.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      cap_addr_reg <= '0;
      full_reg     <= 1'b0;
      overflow_reg <= 1'b0;
    end else if (start_go) begin
      cap_addr_reg <= '0;
      full_reg     <= 1'b0;
      overflow_reg <= 1'b0;
    end else if (cap_stb_int) begin
      if (full_reg) begin
        overflow_reg <= 1'b1;
      end else begin
        cap_addr_reg <= cap_addr_reg + 1'b1;
        if (cap_addr_reg == '1) begin
          full_reg <= 1'b1;
        end
      end
    end
  end

  assign ram_addr = ram_addr_reg;
  assign ram_en   = ram_en_reg;
  assign dp_rst   = dp_rst_reg;
  assign dp_valid = vld_pipe_reg[RAM_LAT-1];
  assign cap_stb  = cap_stb_int;
  assign cap_we   = cap_stb_int & ~full_reg;
  assign cap_addr = cap_addr_reg;
  assign busy     = busy_reg;
  assign done     = done_reg;
  assign overflow = overflow_reg;

endmodule

// File: tb/tb_sample_stream_ctrl.sv
// -----------------------------------------------------------------------------
// tb_sample_stream_ctrl
// Directed scenarios followed by a randomized start/abort/loop_en run, every
// cycle compared against a behavioural model of the run rules.
// -----------------------------------------------------------------------------
module tb_sample_stream_ctrl;

  localparam int ADDR_W      = 5;
  localparam int NUM_SAMPLES = 20;
  localparam int RAM_LAT     = 2;
  localparam int DECIM       = 5;
  localparam int DRAIN_CYC   = 3;
  localparam int OUT_ADDR_W  = 2;
  localparam int CAP_DEPTH   = 1 << OUT_ADDR_W;

  localparam int M_IDLE   = 0;
  localparam int M_STREAM = 1;
  localparam int M_DRAIN  = 2;
  localparam int M_DONE   = 3;

  logic                  CLK;
  logic                  RST;
  logic                  start;
  logic                  abort;
  logic                  loop_en;
  logic [ADDR_W-1:0]     ram_addr;
  logic                  ram_en;
  logic                  dp_rst;
  logic                  dp_valid;
  logic                  cap_stb;
  logic                  cap_we;
  logic [OUT_ADDR_W-1:0] cap_addr;
  logic                  busy;
  logic                  done;
  logic                  overflow;

  int checks = 0;
  int errors = 0;

  // Reference model state.
  int               m_mode;
  int               m_addr;
  bit               m_ram_en;
  int               m_t;          // cycles since the accepted start
  int               m_drain_left;
  bit [RAM_LAT-1:0] m_hist;       // past ram_en values, [0] = previous cycle
  int               m_cap_addr;
  bit               m_full;
  bit               m_ovf;
  bit               lp_r;

  sample_stream_ctrl #(
    .ADDR_W      (ADDR_W),
    .NUM_SAMPLES (NUM_SAMPLES),
    .RAM_LAT     (RAM_LAT),
    .DECIM       (DECIM),
    .DRAIN_CYC   (DRAIN_CYC),
    .OUT_ADDR_W  (OUT_ADDR_W)
  ) dut (
    .CLK      (CLK),
    .RST      (RST),
    .start    (start),
    .abort    (abort),
    .loop_en  (loop_en),
    .ram_addr (ram_addr),
    .ram_en   (ram_en),
    .dp_rst   (dp_rst),
    .dp_valid (dp_valid),
    .cap_stb  (cap_stb),
    .cap_we   (cap_we),
    .cap_addr (cap_addr),
    .busy     (busy),
    .done     (done),
    .overflow (overflow)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog got=running exp=finished");
    $fatal(1, "watchdog expired");
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_mode       = M_IDLE;
    m_addr       = 0;
    m_ram_en     = 1'b0;
    m_t          = 0;
    m_drain_left = 0;
    m_hist       = '0;
    m_cap_addr   = 0;
    m_full       = 1'b0;
    m_ovf        = 1'b0;
  endtask

  // Advance the model across one clock edge with the inputs seen at that edge.
  task automatic model_edge(input bit s, input bit a, input bit l);
    bit busy_now;
    bit stb_now;
    busy_now = (m_mode == M_STREAM) || (m_mode == M_DRAIN);
    stb_now  = busy_now && ((m_t % DECIM) == DECIM - 1);
    if (stb_now) begin
      if (m_full) begin
        m_ovf = 1'b1;
      end else begin
        if (m_cap_addr == CAP_DEPTH - 1) m_full = 1'b1;
        m_cap_addr = (m_cap_addr + 1) % CAP_DEPTH;
      end
    end
    m_hist = {m_hist[RAM_LAT-2:0], m_ram_en};
    if (busy_now) m_t++;
    if (a && m_mode != M_IDLE) begin
      m_mode   = M_IDLE;
      m_addr   = 0;
      m_ram_en = 1'b0;
      m_hist   = '0;
      $display("txn abort t=%0t", $time);
    end else if (s && !a && (m_mode == M_IDLE || m_mode == M_DONE)) begin
      m_mode     = M_STREAM;
      m_addr     = 0;
      m_ram_en   = 1'b1;
      m_t        = 0;
      m_cap_addr = 0;
      m_full     = 1'b0;
      m_ovf      = 1'b0;
      $display("txn start t=%0t", $time);
    end else if (m_mode == M_STREAM) begin
      if (m_addr == NUM_SAMPLES - 1) begin
        if (l) begin
          m_addr = 0;
        end else begin
          m_mode       = M_DRAIN;
          m_ram_en     = 1'b0;
          m_drain_left = RAM_LAT + DRAIN_CYC;
        end
      end else begin
        m_addr++;
      end
    end else if (m_mode == M_DRAIN) begin
      m_drain_left--;
      if (m_drain_left == 0) begin
        m_mode = M_DONE;
        $display("txn done t=%0t ovf=%0d cap_addr=%0d", $time, m_ovf, m_cap_addr);
      end
    end
  endtask

  task automatic compare_all();
    bit busy_e;
    bit stb_e;
    busy_e = (m_mode == M_STREAM) || (m_mode == M_DRAIN);
    stb_e  = busy_e && ((m_t % DECIM) == DECIM - 1);
    check_val("ram_addr", 32'(ram_addr), 32'(m_addr));
    check_val("ram_en",   32'(ram_en),   32'(m_ram_en));
    check_val("dp_rst",   32'(dp_rst),   32'(m_mode == M_IDLE));
    check_val("dp_valid", 32'(dp_valid), 32'(m_hist[RAM_LAT-1]));
    check_val("cap_stb",  32'(cap_stb),  32'(stb_e));
    check_val("cap_we",   32'(cap_we),   32'(stb_e && !m_full));
    check_val("cap_addr", 32'(cap_addr), 32'(m_cap_addr));
    check_val("busy",     32'(busy),     32'(busy_e));
    check_val("done",     32'(done),     32'(m_mode == M_DONE));
    check_val("overflow", 32'(overflow), 32'(m_ovf));
  endtask

  // One clock: inputs are applied here, held across the edge, outputs checked #1 later.
  task automatic cycle(input bit s, input bit a, input bit l);
    start   = s;
    abort   = a;
    loop_en = l;
    @(posedge CLK);
    model_edge(s, a, l);
    #1;
    start = 1'b0;
    abort = 1'b0;
    compare_all();
  endtask

  task automatic run_until_done(input string tag, input int exp_cycles);
    bit seen;
    seen = 1'b0;
    for (int n = 1; n <= 60 && !seen; n++) begin
      cycle(1'b0, 1'b0, 1'b0);
      if (done === 1'b1) begin
        seen = 1'b1;
        check_val(tag, n, exp_cycles);
      end
    end
    if (!seen) check_val({tag, "_timeout"}, 0, 1);
  endtask

  initial begin
    RST     = 1'b1;
    start   = 1'b0;
    abort   = 1'b0;
    loop_en = 1'b0;
    lp_r    = 1'b0;
    model_reset();
    #2;
    RST = 1'b0;
    #1;
    compare_all();
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    RST = 1'b1;

    // Basic run with capture overflow on the fifth strobe.
    cycle(1'b1, 1'b0, 1'b0);
    run_until_done("t1_done_cycle", 25);
    check_val("t2_overflow_in_done", 32'(overflow), 32'd1);
    repeat (3) cycle(1'b0, 1'b0, 1'b0);

    // Restart from DONE; a start while busy must not disturb the run.
    cycle(1'b1, 1'b0, 1'b0);
    check_val("t5_done_cleared", 32'(done), 32'd0);
    repeat (3) cycle(1'b0, 1'b0, 1'b0);
    cycle(1'b1, 1'b0, 1'b0);
    check_val("t5_busy_start_ignored", 32'(ram_addr), 32'd4);
    run_until_done("t5_done_cycle", 21);

    // Looping pass, then a final pass that drains.
    cycle(1'b1, 1'b0, 1'b1);
    repeat (25) cycle(1'b0, 1'b0, 1'b1);
    check_val("t3_wrapped_addr", 32'(ram_addr), 32'd5);
    run_until_done("t3_done_cycle", 20);

    // Abort mid-stream, then simultaneous start+abort in IDLE.
    cycle(1'b1, 1'b0, 1'b0);
    repeat (7) cycle(1'b0, 1'b0, 1'b0);
    check_val("t4_addr_before_abort", 32'(ram_addr), 32'd7);
    cycle(1'b0, 1'b1, 1'b0);
    cycle(1'b1, 1'b1, 1'b0);
    check_val("t4_start_abort_idle", 32'(busy), 32'd0);
    repeat (3) cycle(1'b0, 1'b0, 1'b0);

    // Asynchronous reset in the middle of DRAIN, checked before the next edge.
    cycle(1'b1, 1'b0, 1'b0);
    repeat (21) cycle(1'b0, 1'b0, 1'b0);
    check_val("t6_in_drain", 32'(dp_valid), 32'd1);
    @(negedge CLK);
    #2;
    RST = 1'b0;
    #1;
    model_reset();
    compare_all();
    @(negedge CLK);
    RST = 1'b1;

    // Randomized start/abort/loop_en traffic.
    for (int i = 0; i < 4000; i++) begin
      bit s;
      bit a;
      s = ($urandom_range(0, 15) == 0);
      a = ($urandom_range(0, 49) == 0);
      if ($urandom_range(0, 7) == 0) lp_r = 1'($urandom_range(0, 1));
      cycle(s, a, lp_r);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sample_stream_ctrl.md
Name: sample_stream_ctrl

Overview:
Sequencer for the sample-playback / Costas-loop datapath. It generates the sample-RAM read address, gates the datapath (hold in reset, sample-valid), and produces the decimated capture strobe and write address for the output buffer. It replaces the free-running address counter and the standalone 10 kHz prescaler with one controlled run: start, stream N samples (optionally looping), drain, then report done.

Parameters:
ADDR_W, 22, sample RAM address width
NUM_SAMPLES, 810000, samples per pass; last address is NUM_SAMPLES-1
RAM_LAT, 1, RAM read latency in cycles (>=1)
DECIM, 1000, CLK cycles per capture strobe (10 MHz -> 10 kHz)
DRAIN_CYC, 16, extra cycles after the last valid sample before done
OUT_ADDR_W, 10, capture buffer address width

Ports:
CLK  in  1  system clock
RST  in  1  asynchronous reset, active-low
start  in  1  single-cycle run request
abort  in  1  single-cycle run cancel
loop_en  in  1  wrap to address 0 instead of draining; sampled at last address
ram_addr  out  ADDR_W  sample RAM read address
ram_en  out  1  RAM read enable
dp_rst  out  1  datapath hold-in-reset, active-high
dp_valid  out  1  RAM data at datapath input is valid (ram_en delayed RAM_LAT)
cap_stb  out  1  one-cycle capture tick every DECIM busy cycles
cap_we  out  1  capture buffer write enable
cap_addr  out  OUT_ADDR_W  capture buffer write address
busy  out  1  STREAM or DRAIN
done  out  1  level; run completed
overflow  out  1  sticky; capture strobe dropped because buffer full

Behaviour:
- Reset (RST low, async): state IDLE; ram_addr=0, ram_en=0, dp_rst=1, dp_valid=0, cap_stb=0, cap_we=0, cap_addr=0, busy=0, done=0, overflow=0; latency shift register and decimation counter cleared.
- States: IDLE, STREAM, DRAIN, DONE.
- IDLE: dp_rst=1. start -> STREAM at that edge: ram_addr=0, ram_en=1, dp_rst=0, decim counter=0, cap_addr=0, overflow=0.
- STREAM: ram_addr+1 per cycle. At ram_addr==NUM_SAMPLES-1: loop_en=1 -> ram_addr=0, stay; else -> DRAIN, ram_en=0. Never exceeds NUM_SAMPLES-1.
- DRAIN: ram_en=0; counts RAM_LAT+DRAIN_CYC cycles, then -> DONE. dp_valid falls RAM_LAT cycles after ram_en.
- DONE: done=1, busy=0, dp_rst=0 (datapath state readable), no strobes. start -> STREAM (full restart, done cleared). abort -> IDLE.
- dp_valid = ram_en through RAM_LAT-stage shift register; cleared immediately on abort.
- Decimation: counter runs 0..DECIM-1 only while busy; cap_stb=1 in the cycle counter==DECIM-1, then counter wraps to 0. First strobe DECIM cycles after start edge. Counter frozen and cleared outside busy.
- Capture: cap_we = cap_stb & ~full. cap_addr increments after each write. Write at cap_addr==2^OUT_ADDR_W-1 sets full; later strobes give cap_we=0 and set overflow. full cleared on start.
- Simultaneous start+abort: abort wins. start while busy: ignored. abort in IDLE: no effect.
- abort in STREAM/DRAIN/DONE: next edge IDLE, all outputs to reset values except overflow, cap_addr (hold for readback until next start).
- Address/counter widths: compare against NUM_SAMPLES-1 at ADDR_W bits; NUM_SAMPLES <= 2^ADDR_W checked by elaboration assertion; DECIM>=2.

Decomposition:
- Package mlab_stream_pkg: state enum stream_state_t {IDLE, STREAM, DRAIN, DONE}; shared constants SAMPLE_ADDR_W=22, SAMPLE_COUNT=810000, CAP_DECIM_10K=1000.
- One sub-module: decim_strobe (enable-gated modulo-DECIM counter with clear, one-cycle strobe output); replaces prescaler_10k usage in this path.

Test Plan:
(Parameters for bench: NUM_SAMPLES=20, RAM_LAT=2, DECIM=5, DRAIN_CYC=3, OUT_ADDR_W=2.)
1. Basic run: start at edge 0 -> ram_addr 0..19 on cycles 0..19, ram_en high 20 cycles, dp_valid high cycles 2..21, cap_stb at cycles 4,9,14,19,24, done rises at cycle 25, busy falls same cycle.
2. Capture overflow: run of test 1 -> cap_we on first 4 strobes (cap_addr 0..3), 5th strobe cap_we=0, overflow=1 and stays set through DONE.
3. Loop: loop_en=1 -> ram_addr 19 followed by 0, no DRAIN; clear loop_en, next pass ends -> done 5 cycles after address 19.
4. Abort mid-stream: abort at ram_addr=7 -> next cycle IDLE, ram_en=0, dp_valid=0, dp_rst=1, busy=0, done=0; start+abort same cycle -> stays IDLE.
5. Restart from DONE: start while done=1 -> done=0, ram_addr=0, cap_addr=0, overflow=0, strobe timing identical to test 1; start while busy ignored (ram_addr sequence unbroken).
6. Async reset: drive RST low mid-DRAIN between clock edges -> all outputs at reset values immediately, before next CLK edge.
